scoreboard_regfile: RTL and testbench

SCOREBOARD_REGFILE -- requirements
Module: scoreboard_regfile

---
 rtl/scoreboard_regfile.sv | 73 +++++++
 tb/tb_scoreboard_regfile.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/scoreboard_regfile.sv
// scoreboard_regfile: register file with a busy scoreboard for long-latency results
//   Clk, Clrn        clock, async active-low reset
//   Ra/Rb -> Qa/Qb   combinational read ports; BusyA/BusyB flag pending long-latency writes
//   We/Wr/D          write port 0, single-cycle results (wins on address collision)
//   We1/Wr1/D1       write port 1, long-latency writeback, clears busy
//   RsvEn/Rsv        reserve a register as pending long-latency destination
//   NBusy            registered count of busy registers; Err sticky protocol-error flag
module scoreboard_regfile #(
  parameter int DW = 32,
  parameter int AW = 5,
  parameter int BYPASS = 1
) (
  input  logic          Clk,
  input  logic          Clrn,
  input  logic [AW-1:0] Ra,
  input  logic [AW-1:0] Rb,
  output logic [DW-1:0] Qa,
  output logic [DW-1:0] Qb,
  output logic          BusyA,
  output logic          BusyB,
  input  logic          We,
  input  logic [AW-1:0] Wr,
  input  logic [DW-1:0] D,
  input  logic          We1,
  input  logic [AW-1:0] Wr1,
  input  logic [DW-1:0] D1,
  input  logic          RsvEn,
  input  logic [AW-1:0] Rsv,
  output logic [AW:0]   NBusy,
  output logic          Err
);
  localparam int N = 1 << AW;
  localparam bit BYP = BYPASS != 0;
  logic [DW-1:0] mem [N];
  logic [N-1:0] busy, busy_nxt;
  logic [AW:0] cnt;
  logic wr0, wb1, rsv, err_nxt;
  assign wr0 = We && Wr != '0;
  assign wb1 = We1 && Wr1 != '0;
  assign rsv = RsvEn && Rsv != '0;
  // busy[0] is never set, so register 0 never reports busy
  always_comb begin
    busy_nxt = busy;
    if (wb1) busy_nxt[Wr1] = 1'b0;
    if (rsv) busy_nxt[Rsv] = 1'b1;
    cnt = '0;
    for (int i = 1; i < N; i++) cnt = cnt + (AW+1)'(busy_nxt[i]);
  end
  assign err_nxt = (rsv && busy[Rsv] && !(wb1 && Wr1 == Rsv)) ||
                   (wb1 && !busy[Wr1]) ||
                   (wr0 && ((RsvEn && Rsv == Wr) || busy[Wr]));
  // port 1 written first so port 0 wins a same-address collision
  always_ff @(posedge Clk or negedge Clrn)
    if (!Clrn) begin
      for (int i = 0; i < N; i++) mem[i] <= '0;
      busy <= '0;
      NBusy <= '0;
      Err <= 1'b0;
    end else begin
      if (wb1) mem[Wr1] <= D1;
      if (wr0) mem[Wr] <= D;
      busy <= busy_nxt;
      NBusy <= cnt;
      Err <= Err | err_nxt;
    end
  // reads are gated by Clrn so bypass paths also read 0 during reset
  assign Qa = (!Clrn || Ra == '0) ? '0 : (BYP && We && Wr == Ra) ? D :
              (BYP && We1 && Wr1 == Ra) ? D1 : mem[Ra];
  assign Qb = (!Clrn || Rb == '0) ? '0 : (BYP && We && Wr == Rb) ? D :
              (BYP && We1 && Wr1 == Rb) ? D1 : mem[Rb];
  assign BusyA = Clrn && busy[Ra] && !(BYP && We1 && Wr1 == Ra && !(RsvEn && Rsv == Ra));
  assign BusyB = Clrn && busy[Rb] && !(BYP && We1 && Wr1 == Rb && !(RsvEn && Rsv == Rb));
endmodule

// File: tb/tb_scoreboard_regfile.sv
// tb_scoreboard_regfile: randomized check of scoreboard_regfile (forwarding and non-forwarding) against a behavioural model
module tb_scoreboard_regfile;
  localparam int DW = 32, AW = 5, N = 1 << AW;
  logic Clk = 1'b0, Clrn = 1'b0;
  logic [AW-1:0] Ra = '0, Rb = '0, Wr = '0, Wr1 = '0, Rsv = '0;
  logic [DW-1:0] D = '0, D1 = '0;
  logic We = 1'b0, We1 = 1'b0, RsvEn = 1'b0;
  logic [DW-1:0] qa, qb, qa0, qb0;
  logic busy_a, busy_b, busy_a0, busy_b0, err, err0;
  logic [AW:0] nbusy, nbusy0;
  int tests = 0, fails = 0;
  logic [DW-1:0] m_reg [N];
  bit m_busy [N];
  bit m_err;
  always #5 Clk = ~Clk;
  scoreboard_regfile #(.DW(DW), .AW(AW), .BYPASS(1)) dut (
    .Clk(Clk), .Clrn(Clrn), .Ra(Ra), .Rb(Rb), .Qa(qa), .Qb(qb), .BusyA(busy_a), .BusyB(busy_b),
    .We(We), .Wr(Wr), .D(D), .We1(We1), .Wr1(Wr1), .D1(D1), .RsvEn(RsvEn), .Rsv(Rsv),
    .NBusy(nbusy), .Err(err));
  scoreboard_regfile #(.DW(DW), .AW(AW), .BYPASS(0)) dut0 (
    .Clk(Clk), .Clrn(Clrn), .Ra(Ra), .Rb(Rb), .Qa(qa0), .Qb(qb0), .BusyA(busy_a0), .BusyB(busy_b0),
    .We(We), .Wr(Wr), .D(D), .We1(We1), .Wr1(Wr1), .D1(D1), .RsvEn(RsvEn), .Rsv(Rsv),
    .NBusy(nbusy0), .Err(err0));
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic int m_nbusy();
    int n = 0;
    for (int i = 0; i < N; i++) n += int'(m_busy[i]);
    return n;
  endfunction
  function automatic logic [DW-1:0] exp_q(input logic [AW-1:0] a, input bit byp);
    if (!Clrn || a == 0) return '0;
    if (byp && We && Wr == a) return D;
    if (byp && We1 && Wr1 == a) return D1;
    return m_reg[a];
  endfunction
  function automatic bit exp_b(input logic [AW-1:0] a, input bit byp);
    if (!Clrn || a == 0) return 1'b0;
    if (byp && We1 && Wr1 == a && !(RsvEn && Rsv == a)) return 1'b0;
    return m_busy[a];
  endfunction
  task automatic m_reset();
    for (int i = 0; i < N; i++) begin
      m_reg[i] = '0;
      m_busy[i] = 1'b0;
    end
    m_err = 1'b0;
  endtask
  task automatic idle();
    We = 1'b0; We1 = 1'b0; RsvEn = 1'b0;
  endtask
  // compare combinational outputs, apply one edge to the model, compare registered outputs
  task automatic tick();
    #1;
    chk("qa", qa, exp_q(Ra, 1)); chk("qb", qb, exp_q(Rb, 1));
    chk("busy_a", busy_a, exp_b(Ra, 1)); chk("busy_b", busy_b, exp_b(Rb, 1));
    chk("qa_nobyp", qa0, exp_q(Ra, 0)); chk("qb_nobyp", qb0, exp_q(Rb, 0));
    chk("busy_a_nobyp", busy_a0, exp_b(Ra, 0)); chk("busy_b_nobyp", busy_b0, exp_b(Rb, 0));
    if (Clrn) begin
      if (RsvEn && Rsv != 0 && m_busy[Rsv] && !(We1 && Wr1 == Rsv)) m_err = 1'b1;
      if (We1 && Wr1 != 0 && !m_busy[Wr1]) m_err = 1'b1;
      if (We && Wr != 0 && ((RsvEn && Rsv == Wr) || m_busy[Wr])) m_err = 1'b1;
      if (We1 && Wr1 != 0) begin
        m_reg[Wr1] = D1;
        m_busy[Wr1] = 1'b0;
      end
      if (We && Wr != 0) m_reg[Wr] = D;
      if (RsvEn && Rsv != 0) m_busy[Rsv] = 1'b1;
    end
    @(posedge Clk); #1;
    chk("nbusy", nbusy, m_nbusy()); chk("err", err, m_err);
    chk("nbusy_nobyp", nbusy0, m_nbusy()); chk("err_nobyp", err0, m_err);
  endtask
  // reset asserted mid-cycle and held across an edge with writes requested
  task automatic reset_pulse();
    We = 1'b1; Wr = Ra; D = $urandom; We1 = 1'b1; Wr1 = Rb; D1 = $urandom;
    RsvEn = 1'b1; Rsv = 5'd6;
    #2 Clrn = 1'b0;
    m_reset();
    #1;
    chk("rst_qa", qa, 0); chk("rst_qb", qb, 0); chk("rst_busy_a", busy_a, 0);
    chk("rst_nbusy", nbusy, 0); chk("rst_err", err, 0);
    @(posedge Clk); #1;
    chk("rst_hold_nbusy", nbusy, 0); chk("rst_hold_qa", qa, 0); chk("rst_hold_qa_nobyp", qa0, 0);
    Clrn = 1'b1;
    idle();
  endtask
  initial begin
    m_reset();
    #3 Clrn = 1'b1;
    @(posedge Clk); #1;
    chk("init_nbusy", nbusy, 0); chk("init_err", err, 0);
    idle(); We = 1'b1; Wr = 5'd5; D = 32'hDEADBEEF; Ra = 5'd5; Rb = 5'd0;
    #1 chk("byp_we", qa, 32'hDEADBEEF); chk("nobyp_we", qa0, 0);
    tick();
    idle();
    #1 chk("nobyp_after", qa0, 32'hDEADBEEF);
    We = 1'b1; Wr = 5'd0; D = 32'h1234; Ra = 5'd0;
    tick();
    chk("r0_qa", qa, 0); chk("r0_nbusy", nbusy, 0); chk("r0_err", err, 0);
    idle(); RsvEn = 1'b1; Rsv = 5'd7; Ra = 5'd7;
    tick();
    idle();
    #1 chk("rsv7_busy", busy_a, 1); chk("rsv7_nbusy", nbusy, 1);
    We1 = 1'b1; Wr1 = 5'd7; D1 = 32'h55;
    #1 chk("wb7_qa", qa, 32'h55); chk("wb7_busy", busy_a, 0); chk("wb7_busy_nobyp", busy_a0, 1);
    tick();
    chk("wb7_nbusy", nbusy, 0); chk("wb7_err", err, 0);
    idle(); RsvEn = 1'b1; Rsv = 5'd9;
    tick();
    We1 = 1'b1; Wr1 = 5'd9; D1 = 32'h99; Ra = 5'd9;
    #1 chk("setclr_busy", busy_a, 1);
    tick();
    idle();
    #1 chk("setclr_after", busy_a, 1); chk("setclr_nbusy", nbusy, 1); chk("setclr_err", err, 0);
    RsvEn = 1'b1; Rsv = 5'd3;
    tick();
    idle(); We = 1'b1; Wr = 5'd3; D = 32'hAAAA; We1 = 1'b1; Wr1 = 5'd3; D1 = 32'hBBBB;
    tick();
    idle(); Ra = 5'd3;
    #1 chk("coll_qa", qa, 32'hAAAA); chk("coll_busy", busy_a, 0); chk("coll_err", err, 1);
    reset_pulse();
    for (int r = 3; r <= 5; r++) begin
      RsvEn = 1'b1; Rsv = 5'(r);
      tick();
    end
    idle();
    chk("rsv3_nbusy", nbusy, 3);
    We1 = 1'b1; Wr1 = 5'd8; D1 = 32'h8;
    tick();
    idle();
    chk("wb_notbusy_err", err, 1);
    tick();
    chk("err_sticky", err, 1);
    Ra = 5'd3;
    reset_pulse();
    for (int c = 0; c < 600; c++) begin
      if (c % 60 == 59) reset_pulse();
      Ra = 5'($urandom_range(0, 7)); Rb = 5'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) Rb = 5'($urandom);
      We = 1'($urandom); Wr = 5'($urandom_range(0, 7)); D = $urandom;
      We1 = 1'($urandom); Wr1 = 5'($urandom_range(0, 7)); D1 = $urandom;
      RsvEn = 1'($urandom); Rsv = 5'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) begin
        for (int i = 1; i < 8; i++)
          if (m_busy[i]) Wr1 = 5'(i);
      end
      tick();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
